// File: rtl/gat_pkg.sv
// -----------------------------------------------------------------------------
// gat_pkg
// Shared definitions for the feature BRAM controller:
//   - feat_state_e : controller state encoding (IDLE, FILL, STREAM, DONE)
//   - calc_depth   : features per layer (subgraphs * features per subgraph)
//   - calc_words   : RAM words per layer (features / lanes per word)
//   - calc_clog2   : address width helper, never returns less than 1 bit
// -----------------------------------------------------------------------------
package gat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feat_state_e;

    function automatic int calc_depth(input int num_subgraphs, input int num_feature_out);
        return num_subgraphs * num_feature_out;
    endfunction

    function automatic int calc_words(input int depth, input int num_ch);
        return depth / num_ch;
    endfunction

    // A zero-width vector is illegal, so degenerate sizes still get one bit.
    function automatic int calc_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : gat_pkg

// File: rtl/feat_bram_sdp.sv
// -----------------------------------------------------------------------------
// feat_bram_sdp
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the word being written in the same cycle returns the old contents
// (read-first), which is what block RAM in read-first mode provides.
//
// Ports
//   clk    : clock
//   we     : write enable
//   waddr  : write word address
//   wdata  : write data (WIDTH bits)
//   raddr  : read word address
//   rdata  : registered read data, valid one cycle after raddr
// -----------------------------------------------------------------------------
module feat_bram_sdp #(
    parameter int WIDTH = 32,
    parameter int WORDS = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and its output register carry no reset so the tools can
    // map them onto block RAM; a reset would force a flop-based implementation.
    // Both assignments are non-blocking, so the read samples the word before
    // this cycle's write lands: that ordering is what makes the port read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule : feat_bram_sdp

// File: rtl/feat_bram_ctrl.sv
// -----------------------------------------------------------------------------
// feat_bram_ctrl
// Collects one layer of output features into a BRAM and serves host reads.
// A start pulse begins a layer: an optional FILL phase writes INIT_VALUE into
// every word, then STREAM accepts NUM_CH features per valid/ready beat and
// stores them in order. After the last word the controller sits in DONE until
// the next start. The host read port works in every state.
//
// Build option
//   FEAT_BRAM_INIT_FILL_EN : when defined, start enters FILL (WORDS cycles)
//                            before STREAM, so unwritten features read
//                            INIT_VALUE. When undefined, start goes straight
//                            to STREAM and no fill logic is built.
//
// Ports
//   clk             : clock
//   rst             : asynchronous active-high reset
//   start           : single-cycle pulse, begins a layer (IDLE/DONE only)
//   feat_valid      : input beat valid
//   feat_ready      : high only in STREAM
//   feat_data       : NUM_CH lanes, lane k = feat_data[k*DATA_WIDTH +: DATA_WIDTH]
//   busy            : FILL or STREAM in progress
//   done            : layer complete, held until the next accepted start
//   wr_count        : beats written in the current layer
//   feat_bram_addrb : host byte address, feature index = addrb[ADDR_W+1:2]
//   feat_bram_dout  : selected feature zero-extended, one cycle after address
// -----------------------------------------------------------------------------
module feat_bram_ctrl
    import gat_pkg::*;
#(
    parameter  int DATA_WIDTH      = 8,
    parameter  int NUM_FEATURE_OUT = 16,
    parameter  int NUM_SUBGRAPHS   = 2708,
    parameter  int NUM_CH          = 4,
    parameter  int INIT_VALUE      = 50,
    localparam int DEPTH           = calc_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
    localparam int WORDS           = calc_words(DEPTH, NUM_CH),
    localparam int ADDR_W          = calc_clog2(DEPTH),
    localparam int WADDR_W         = calc_clog2(WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         feat_valid,
    output logic                         feat_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] feat_data,
    output logic                         busy,
    output logic                         done,
    output logic [WADDR_W:0]             wr_count,
    input  logic [ADDR_W+1:0]            feat_bram_addrb,
    output logic [31:0]                  feat_bram_dout
);

    localparam int                 ROW_W     = NUM_CH * DATA_WIDTH;
    localparam int                 LANE_W    = calc_clog2(NUM_CH);
    localparam logic [WADDR_W-1:0] LAST_WORD = WADDR_W'(WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] INIT_LANE = DATA_WIDTH'(INIT_VALUE);

    // ------------------------------------------------------------------
    // Write-side control
    // ------------------------------------------------------------------
    feat_state_e          state_q,    state_d;
    logic [WADDR_W-1:0]   ptr_q,      ptr_d;
    logic [WADDR_W:0]     wr_count_q, wr_count_d;
    logic                 done_q,     done_d;

    logic                 ram_we;
    logic [WADDR_W-1:0]   ram_waddr;
    logic [ROW_W-1:0]     ram_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            wr_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_count_q <= wr_count_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_count_d = wr_count_q;
        done_d     = done_q;
        ram_we     = 1'b0;
        ram_waddr  = ptr_q;
        ram_wdata  = feat_data;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ptr_d      = '0;
                    wr_count_d = '0;
                    done_d     = 1'b0;
`ifdef FEAT_BRAM_INIT_FILL_EN
                    state_d    = ST_FILL;
`else
                    state_d    = ST_STREAM;
`endif
                end
            end

`ifdef FEAT_BRAM_INIT_FILL_EN
            ST_FILL: begin
                ram_we    = 1'b1;
                ram_wdata = {NUM_CH{INIT_LANE}};
                if (ptr_q == LAST_WORD) begin
                    ptr_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    ptr_d = ptr_q + WADDR_W'(1);
                end
            end
`endif

            ST_STREAM: begin
                if (feat_valid) begin
                    ram_we     = 1'b1;
                    wr_count_d = wr_count_q + (WADDR_W+1)'(1);
                    // The pointer parks on the last word instead of wrapping.
                    if (ptr_q == LAST_WORD) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + WADDR_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifndef FEAT_BRAM_INIT_FILL_EN
    // The fill constant only feeds the FILL phase.
    logic [DATA_WIDTH-1:0] unused_init_lane;
    assign unused_init_lane = INIT_LANE;
`endif

    assign feat_ready = (state_q == ST_STREAM);
    assign busy       = (state_q == ST_FILL) || (state_q == ST_STREAM);
    assign done       = done_q;
    assign wr_count   = wr_count_q;

    // ------------------------------------------------------------------
    // Host read side
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  host_idx;
    logic               host_in_range;
    logic [WADDR_W-1:0] host_word;
    logic [WADDR_W-1:0] ram_raddr;
    logic [ROW_W-1:0]   ram_rdata;

    logic               rd_ok_q,   rd_ok_d;
    logic [LANE_W-1:0]  rd_lane_q, rd_lane_d;

    // Byte-select bits carry no information for feature-granular reads.
    logic [1:0] unused_byte_sel;
    assign unused_byte_sel = feat_bram_addrb[1:0];

    always_comb begin
        host_idx      = feat_bram_addrb[ADDR_W+1:2];
        host_in_range = (32'(host_idx) < DEPTH);
        host_word     = WADDR_W'(32'(host_idx) / NUM_CH);
        // Out-of-range indices still drive a legal word address; the
        // registered range flag masks the data that comes back.
        ram_raddr     = host_in_range ? host_word : '0;
        rd_ok_d       = host_in_range;
        rd_lane_d     = LANE_W'(32'(host_idx) % NUM_CH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ok_q   <= 1'b0;
            rd_lane_q <= '0;
        end else begin
            rd_ok_q   <= rd_ok_d;
            rd_lane_q <= rd_lane_d;
        end
    end

    // Lane select sits after the RAM output register, aligned with the
    // registered lane index, so dout appears one cycle after the address.
    logic [DATA_WIDTH-1:0] rd_lane_data;
    always_comb begin
        rd_lane_data   = ram_rdata[32'(rd_lane_q)*DATA_WIDTH +: DATA_WIDTH];
        feat_bram_dout = rd_ok_q ? 32'(rd_lane_data) : 32'd0;
    end

    feat_bram_sdp #(
        .WIDTH (ROW_W),
        .WORDS (WORDS),
        .AW    (WADDR_W)
    ) u_sdp (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule : feat_bram_ctrl

// File: tb/tb_feat_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_feat_bram_ctrl
// Self-checking bench for feat_bram_ctrl at default parameters. A feature-level
// model (one entry per feature, plus layer progress counters) predicts busy,
// feat_ready, done, wr_count and feat_bram_dout every cycle; directed
// sequences add hand-computed literal expectations. Works with or without
// FEAT_BRAM_INIT_FILL_EN defined.
// -----------------------------------------------------------------------------
module tb_feat_bram_ctrl;

    localparam int DW    = 8;
    localparam int NF    = 16;
    localparam int NS    = 2708;
    localparam int NCH   = 4;
    localparam int INIT  = 50;
    localparam int DEPTH = NS * NF;       // 43328 features
    localparam int WORDS = DEPTH / NCH;   // 10832 words

`ifdef FEAT_BRAM_INIT_FILL_EN
    localparam int OLD7 = INIT;           // layer 2 fill overwrote layer 1 data
`else
    localparam int OLD7 = 7;              // layer 1 beat 7 lane 0 = 7 + 0
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              feat_valid = 1'b0;
    logic              feat_ready;
    logic [NCH*DW-1:0] feat_data = '0;
    logic              busy;
    logic              done;
    logic [14:0]       wr_count;
    logic [17:0]       addrb = '0;
    logic [31:0]       dout;

    always #5 clk = ~clk;

    feat_bram_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .feat_valid      (feat_valid),
        .feat_ready      (feat_ready),
        .feat_data       (feat_data),
        .busy            (busy),
        .done            (done),
        .wr_count        (wr_count),
        .feat_bram_addrb (addrb),
        .feat_bram_dout  (dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: features are stored individually; layer progress is
    // tracked as "fill cycles left", "streaming" and "beats accepted".
    // ------------------------------------------------------------------
    int mem_m   [DEPTH];
    bit known_m [DEPTH];
    bit m_stream    = 1'b0;
    bit m_done      = 1'b0;
    int m_fill_left = 0;
    int m_count     = 0;
    int exp_dout    = 0;
    bit exp_known   = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                // An abort leaves the memory contents undefined.
                if (m_stream || m_fill_left > 0) begin
                    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
                end
                m_stream    = 1'b0;
                m_done      = 1'b0;
                m_fill_left = 0;
                m_count     = 0;
                exp_dout    = 0;
                exp_known   = 1'b1;
            end else begin
                int idx;
                idx = int'(addrb) / 4;
                // Read resolves before this edge's write (read-first).
                if (idx >= DEPTH) begin
                    exp_dout  = 0;
                    exp_known = 1'b1;
                end else begin
                    exp_dout  = mem_m[idx];
                    exp_known = known_m[idx];
                end

                if (m_fill_left > 0) begin
                    int w;
                    w = WORDS - m_fill_left;
                    for (int k = 0; k < NCH; k++) begin
                        mem_m[w*NCH+k]   = INIT;
                        known_m[w*NCH+k] = 1'b1;
                    end
                    m_fill_left--;
                    if (m_fill_left == 0) m_stream = 1'b1;
                end else if (m_stream) begin
                    if (feat_valid) begin
                        for (int k = 0; k < NCH; k++) begin
                            mem_m[m_count*NCH+k]   = int'(feat_data[k*DW +: DW]);
                            known_m[m_count*NCH+k] = 1'b1;
                        end
                        m_count++;
                        if (m_count == WORDS) begin
                            m_stream = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                end else if (start) begin
                    m_done  = 1'b0;
                    m_count = 0;
`ifdef FEAT_BRAM_INIT_FILL_EN
                    m_fill_left = WORDS;
`else
                    m_stream = 1'b1;
`endif
                end
            end
        end
    end

    // Compare process: outputs sampled mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy",       busy,       (m_fill_left > 0 || m_stream) ? 1 : 0);
                check("feat_ready", feat_ready, m_stream ? 1 : 0);
                check("done",       done,       m_done ? 1 : 0);
                check("wr_count",   wr_count,   m_count);
                if (exp_known) check("dout", dout, exp_dout);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [NCH*DW-1:0] beat(input int n, input int off);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = DW'(n + k + off);
        return r;
    endfunction

    function automatic logic [17:0] sweep_addr(input int cyc);
        return 18'((cyc * 148 + cyc % 4) % (4 * DEPTH + 256));
    endfunction

    task automatic rd_lit(input string name, input int a, input int exp);
        addrb = 18'(a);
        tick();
        @(negedge clk);
        check(name, dout, exp);
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (!feat_ready && g < 30000) begin
            @(negedge clk);
            g++;
        end
        check("wait_ready", feat_ready, 1);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int  nb;
        int  cyc;
        bit  hs;
        bit  pulsed;
        bit  chk_101;
        bit  chk_rw;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_busy",     busy,       0);
        check("rst_done",     done,       0);
        check("rst_ready",    feat_ready, 0);
        check("rst_wr_count", wr_count,   0);
        check("rst_dout",     dout,       0);
        tick();
        rst = 1'b0;
        tick();

        // Layer 1: start
        pulse_start();
`ifdef FEAT_BRAM_INIT_FILL_EN
        begin
            int cnt;
            cnt = 0;
            while (cnt < 30000) begin
                @(negedge clk);
                if (feat_ready) break;
                cnt++;
            end
            check("fill_cycles", cnt, WORDS);
            rd_lit("fill_rd_addr0", 0, 'h32);
            tick();
        end
`else
        @(negedge clk);
        check("ready_after_start", feat_ready, 1);
        tick();
`endif

        // Layer 1: toggled valid for the first 120 beats, start pulse at
        // wr_count=100, then continuous valid.
        nb = 0; cyc = 0; pulsed = 1'b0; chk_101 = 1'b0;
        while (nb < WORDS && cyc < 40000) begin
            feat_data  = beat(nb, 0);
            feat_valid = (nb < 120) ? (cyc % 2 == 0) : 1'b1;
            addrb      = sweep_addr(cyc);
            if (nb == 100 && !pulsed && feat_valid) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            if (chk_101) begin
                check("start_ignored_wr_count", wr_count, 101);
                chk_101 = 1'b0;
            end
            hs = feat_valid && feat_ready;
            tick();
            if (start) chk_101 = 1'b1;
            start = 1'b0;
            if (hs) nb++;
            cyc++;
        end
        feat_valid = 1'b0;
        check("l1_beats", nb, WORDS);
        @(negedge clk);
        check("l1_done",     done,     1);
        check("l1_wr_count", wr_count, WORDS);

        // Hand-computed reads: index 5 = beat 1 lane 1 = 2;
        // index DEPTH-1 = beat 10831 lane 3 = 10834 mod 256 = 82.
        rd_lit("rd_idx5",    20,              2);
        rd_lit("rd_oor",     4 * DEPTH,       0);
        rd_lit("rd_last",    4 * (DEPTH - 1), 82);
        rd_lit("rd_byte_ign", 23,             2);
        tick();

        // Layer 2: same-cycle read/write of word 7, then abort at wr_count=500.
        pulse_start();
        wait_ready();
        nb = 0; cyc = 0; chk_rw = 1'b0;
        while (nb < 500 && cyc < 2000) begin
            feat_data  = beat(nb, 'h80);
            feat_valid = 1'b1;
            addrb      = (nb == 7) ? 18'd112 : sweep_addr(cyc + 7);
            @(negedge clk);
            if (chk_rw) begin
                check("rw_same_word_old", dout, OLD7);
                chk_rw = 1'b0;
            end
            hs = feat_valid && feat_ready;
            tick();
            if (hs) begin
                if (nb == 7) chk_rw = 1'b1;
                nb++;
            end
            cyc++;
        end
        check("l2_beats", nb, 500);
        @(negedge clk);
        check("pre_abort_wr_count", wr_count, 500);
        tick();
        rst        = 1'b1;
        feat_valid = 1'b0;
        @(negedge clk);
        check("abort_busy",     busy,       0);
        check("abort_done",     done,       0);
        check("abort_ready",    feat_ready, 0);
        check("abort_wr_count", wr_count,   0);
        check("abort_dout",     dout,       0);
        tick();
        rst = 1'b0;
        tick();

        // Layer 3: restart from word 0.
        pulse_start();
        wait_ready();
        nb = 0; cyc = 0;
        while (nb < 20 && cyc < 200) begin
            feat_data  = beat(nb, 'h40);
            feat_valid = 1'b1;
            addrb      = sweep_addr(cyc + 3);
            @(negedge clk);
            hs = feat_valid && feat_ready;
            tick();
            if (hs) nb++;
            cyc++;
        end
        feat_valid = 1'b0;
        @(negedge clk);
        check("l3_wr_count", wr_count, 20);
        rd_lit("l3_rd_idx0", 0,  'h40);
        rd_lit("l3_rd_idx6", 24, 'h40 + 1 + 2);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_feat_bram_ctrl
